// File: rtl/uarc_sender.sv
// uarc_sender: transmit end of the UARC bus.
// Turns one core request (kill/incept/send/stream) into a bus transaction on one
// selected bus, waits for the matching per-bus ack and reports completion, timeout
// or a bad bus index back to the core.
// Ports:
//   clk, reset                  clock; async active-low reset
//   req_valid/req_ready         core request handshake
//   req_op/bus/last/data        request (op 00 kill, 01 incept, 10 send, 11 stream)
//   req_incept_permission/address, self_permission/address   payload inputs
//   global_kill/incept/send/stream   registered op strobes (at most one high)
//   global_data/self_*/incept_*      registered payload, held while idle
//   sender_enables              registered one-hot bus select
//   sender_*_acks               per-bus acks from the interconnect
//   done_valid/done_status      one-cycle completion pulse: 00 ok, 01 timeout, 10 bad bus
module uarc_sender #(
  parameter  int WORD_MAG    = 5,
  parameter  int TOTAL_BUSES = 1,
  parameter  int TIMEOUT     = 0,
  localparam int WORD_WIDTH  = 1 << WORD_MAG,
  localparam int BUS_IDX_W   = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [BUS_IDX_W-1:0]   req_bus,
  input  logic                   req_last,
  input  logic [WORD_WIDTH-1:0]  req_data,
  input  logic [WORD_WIDTH-1:0]  req_incept_permission,
  input  logic [WORD_WIDTH-1:0]  req_incept_address,
  input  logic [WORD_WIDTH-1:0]  self_permission,
  input  logic [WORD_WIDTH-1:0]  self_address,
  output logic                   global_kill,
  output logic                   global_incept,
  output logic                   global_send,
  output logic                   global_stream,
  output logic [WORD_WIDTH-1:0]  global_data,
  output logic [WORD_WIDTH-1:0]  global_self_permission,
  output logic [WORD_WIDTH-1:0]  global_self_address,
  output logic [WORD_WIDTH-1:0]  global_incept_permission,
  output logic [WORD_WIDTH-1:0]  global_incept_address,
  output logic [TOTAL_BUSES-1:0] sender_enables,
  input  logic [TOTAL_BUSES-1:0] sender_kill_acks,
  input  logic [TOTAL_BUSES-1:0] sender_incept_acks,
  input  logic [TOTAL_BUSES-1:0] sender_send_acks,
  input  logic [TOTAL_BUSES-1:0] sender_stream_acks,
  output logic                   done_valid,
  output logic [1:0]             done_status
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] OP_INCEPT = 2'd1, OP_SEND = 2'd2, OP_STREAM = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [1:0]             op_q;
  logic                   last_q;
  logic [3:0]             strb_q;   // {stream, send, incept, kill}
  logic [TOTAL_BUSES-1:0] bus_dec, ack_vec;
  logic                   accept, bad_bus, ack_hit, to_hit;

  for (genvar i = 0; i < TOTAL_BUSES; i++) begin : g_dec
    assign bus_dec[i] = (int'(req_bus) == i);
  end

  assign req_ready = (state == S_IDLE) || (state == S_HOLD);
  assign accept    = req_valid && req_ready;
  assign bad_bus   = (int'(req_bus) >= TOTAL_BUSES);

  // The enable register is one-hot on the latched bus throughout WAIT, so masking
  // the op's ack vector with it picks exactly the ack that counts.
  always_comb begin
    ack_vec = sender_kill_acks;
    case (op_q)
      OP_INCEPT: ack_vec = sender_incept_acks;
      OP_SEND:   ack_vec = sender_send_acks;
      OP_STREAM: ack_vec = sender_stream_acks;
      default:   ;
    endcase
  end

  assign ack_hit = (state == S_WAIT) && |(ack_vec & sender_enables);
  // Ack has priority over a timeout landing on the same edge.
  assign to_hit  = (TIMEOUT > 0) && (state == S_WAIT) && !ack_hit &&
                   (int'(cnt) + 1 >= TIMEOUT);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: if (accept && !bad_bus) state_d = S_WAIT;
      S_WAIT: begin
        if (ack_hit)     state_d = (op_q == OP_STREAM && !last_q) ? S_HOLD : S_IDLE;
        else if (to_hit) state_d = S_IDLE;
      end
      S_HOLD: if (accept) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_WAIT && state != S_WAIT)  cnt_d = '0;
    else if (state == S_WAIT && TIMEOUT > 0)   cnt_d = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q                     <= '0;
      last_q                   <= 1'b0;
      strb_q                   <= '0;
      sender_enables           <= '0;
      global_data              <= '0;
      global_self_permission   <= '0;
      global_self_address      <= '0;
      global_incept_permission <= '0;
      global_incept_address    <= '0;
      done_valid               <= 1'b0;
      done_status              <= 2'b00;
    end else begin
      done_valid <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (bad_bus) begin
            done_valid  <= 1'b1;
            done_status <= 2'b10;
          end else begin
            op_q                     <= req_op;
            last_q                   <= req_last;
            global_data              <= req_data;
            global_incept_permission <= req_incept_permission;
            global_incept_address    <= req_incept_address;
            global_self_permission   <= self_permission;
            global_self_address      <= self_address;
            sender_enables           <= bus_dec;
            strb_q                   <= 4'b0001 << req_op;
          end
        end
        S_WAIT: if (ack_hit || to_hit) begin
          done_valid  <= 1'b1;
          done_status <= ack_hit ? 2'b00 : 2'b01;
          strb_q      <= '0;
          // Mid-stream the bus stays owned: enable holds into HOLD.
          if (state_d != S_HOLD) sender_enables <= '0;
        end
        // Continuation word: op and bus are taken from the held stream.
        S_HOLD: if (accept) begin
          last_q      <= req_last;
          global_data <= req_data;
          strb_q      <= 4'b1000;
        end
        default: ;
      endcase
    end
  end

  assign {global_stream, global_send, global_incept, global_kill} = strb_q;

endmodule
